// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with per-byte write enables, configurable read latency and
// read-during-write behaviour, zeroed by a sequential clear engine after reset or on request.
module ram_sdp_clr #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int SIZE     = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_busy
);

    localparam int                LP_LANES = DATA_W / 8;
    localparam logic [ADDR_W:0]   LP_SIZE  = (ADDR_W + 1)'(SIZE);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(SIZE - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [0:SIZE-1];
    logic [DATA_W-1:0]   r_rd_data1;
    logic                r_rd_v1;

    logic                w_idle;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_rd_inr;
    logic                w_rdw_hit;
    logic [DATA_W-1:0]   w_mem_rd;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_idle    = (r_state == ST_IDLE);
    // A clear request in the same cycle wins over the write, which is dropped.
    assign w_wr_acc  = w_idle & i_wr_en & ~i_clear & ({1'b0, i_wr_addr} < LP_SIZE);
    assign w_rd_acc  = w_idle & i_rd_en;
    assign w_rd_inr  = ({1'b0, i_rd_addr} < LP_SIZE);
    assign w_mem_rd  = w_rd_inr ? r_mem[i_rd_addr] : '0;
    assign w_rdw_hit = (RDW_MODE != 0) & w_wr_acc & (i_wr_addr == i_rd_addr);

    genvar gi;
    generate
        for (gi = 0; gi < LP_LANES; gi++) begin : g_lane
            assign w_rd_word[gi*8 +: 8] = (w_rdw_hit && i_wr_be[gi]) ?
                                          i_wr_data[gi*8 +: 8] : w_mem_rd[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_acc) begin
            for (int b = 0; b < LP_LANES; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data1 <= '0;
            r_rd_v1    <= 1'b0;
        end else begin
            r_rd_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data1 <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_rd_data2;
            logic              r_rd_v2;

            // Second stage keeps draining even while the clear engine runs.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_rd_data2 <= '0;
                    r_rd_v2    <= 1'b0;
                end else begin
                    r_rd_v2 <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rd_data2 <= r_rd_data1;
                    end
                end
            end

            assign o_rd_data  = r_rd_data2;
            assign o_rd_valid = r_rd_v2;
        end else begin : g_no_out_reg
            assign o_rd_data  = r_rd_data1;
            assign o_rd_valid = r_rd_v1;
        end
    endgenerate

    assign o_busy = r_busy;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Scoreboard bench: two RAM instances share stimulus; A is SIZE=8/write-first/registered
// output, B is SIZE=6/old-data/direct output, so each vector carries two expected words.
module tb_ram_sdp_clr;

    typedef struct {
        logic [15:0] data;
        int          issue;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid, a_busy, b_busy;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    ram_sdp_clr #(.DATA_W(16), .ADDR_W(3), .SIZE(8), .RDW_MODE(1), .OUT_REG(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(a_data), .o_rd_valid(a_valid), .o_busy(a_busy)
    );

    ram_sdp_clr #(.DATA_W(16), .ADDR_W(3), .SIZE(6), .RDW_MODE(0), .OUT_REG(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(b_data), .o_rd_valid(b_valid), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitors: pop one expectation per presented read and check data and latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_valid) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", {16'h0, a_data}, 32'hFFFF_FFFF);
            end else begin
                e = qa.pop_front();
                $display("A read data=%h exp=%h lat=%0d", a_data, e.data, cyc - e.issue);
                chk("a_rd_data", {16'h0, a_data}, {16'h0, e.data});
                chk("a_latency", cyc - e.issue, 1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_valid) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", {16'h0, b_data}, 32'hFFFF_FFFF);
            end else begin
                e = qb.pop_front();
                $display("B read data=%h exp=%h lat=%0d", b_data, e.data, cyc - e.issue);
                chk("b_rd_data", {16'h0, b_data}, {16'h0, e.data});
                chk("b_latency", cyc - e.issue, 0);
            end
        end
    end

    task automatic idle_in();
        clear = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0; rd_en = 0; rd_addr = 0;
    endtask

    task automatic drive(input logic c, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [1:0] be, input logic re,
                         input logic [2:0] ra, input logic [15:0] ea, input logic [15:0] eb,
                         input logic push);
        exp_t e;
        clear = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        if (push) begin
            e.issue = cyc + 1;
            e.data  = ea; qa.push_back(e);
            e.data  = eb; qb.push_back(e);
        end
    endtask

    task automatic step(input logic c, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic [1:0] be, input logic re,
                        input logic [2:0] ra, input logic [15:0] ea, input logic [15:0] eb,
                        input logic push);
        @(negedge clk);
        drive(c, we, wa, wd, be, re, ra, ea, eb, push);
        @(posedge clk);
        #1 idle_in();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        step(0, 1, a, d, be, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] ea, input logic [15:0] eb);
        step(0, 0, 0, 0, 0, 1, a, ea, eb, 1);
    endtask

    task automatic wrrd(input logic [2:0] wa, input logic [15:0] wd, input logic [1:0] be,
                        input logic [2:0] ra, input logic [15:0] ea, input logic [15:0] eb);
        step(0, 1, wa, wd, be, 1, ra, ea, eb, 1);
    endtask

    task automatic check_reset_outputs();
        chk("a_busy_in_reset",  {31'h0, a_busy},  1);
        chk("a_valid_in_reset", {31'h0, a_valid}, 0);
        chk("a_data_in_reset",  {16'h0, a_data},  0);
        chk("b_busy_in_reset",  {31'h0, b_busy},  1);
        chk("b_valid_in_reset", {31'h0, b_valid}, 0);
        chk("b_data_in_reset",  {16'h0, b_data},  0);
    endtask

    // Release reset between edges; busy must drop after edge SIZE of each instance.
    task automatic release_check();
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clk);
            chk("a_busy_after_release", {31'h0, a_busy}, (m < 8) ? 1 : 0);
            chk("b_busy_after_release", {31'h0, b_busy}, (m < 6) ? 1 : 0);
        end
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        release_check();

        // Every address reads zero after the power-up clear.
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 16'h0000);

        // Byte-lane merge across two writes.
        wr(3, 16'h1234, 2'b11);
        wr(3, 16'hFF00, 2'b10);
        rd(3, 16'hFF34, 16'hFF34);
        wr(1, 16'h00A5, 2'b01);
        rd(1, 16'h00A5, 16'h00A5);

        // Same-address read during write: A write-first merged, B old data.
        wr(2, 16'h0011, 2'b11);
        wrrd(2, 16'h005A, 2'b01, 2, 16'h005A, 16'h0011);
        wrrd(2, 16'hAB00, 2'b10, 2, 16'hAB5A, 16'h005A);
        wrrd(4, 16'h7777, 2'b11, 2, 16'hAB5A, 16'hAB5A);
        wrrd(2, 16'hFFFF, 2'b00, 2, 16'hAB5A, 16'hAB5A);
        rd(2, 16'hAB5A, 16'hAB5A);
        rd(4, 16'h7777, 16'h7777);

        // Addresses 6 and 7 are beyond B's depth.
        wr(7, 16'hBEEF, 2'b11);
        rd(7, 16'hBEEF, 16'h0000);
        wr(6, 16'hCAFE, 2'b11);
        rd(6, 16'hCAFE, 16'h0000);
        wrrd(7, 16'h1111, 2'b11, 7, 16'h1111, 16'h0000);
        rd(7, 16'h1111, 16'h0000);

        // Fill, then clear with a colliding write to addr 0 and a read of addr 5.
        for (int a = 0; a < 8; a++) wr(3'(a), 16'h1020 + 16'(16'h0101 * a), 2'b11);
        rd(0, 16'h1020, 16'h1020);
        rd(7, 16'h1727, 16'h0000);
        step(1, 1, 0, 16'hDEAD, 2'b11, 1, 5, 16'h1525, 16'h1525, 1);
        for (int m = 0; m <= 8; m++) begin
            @(negedge clk);
            chk("a_busy_clear", {31'h0, a_busy}, (m < 8) ? 1 : 0);
            chk("b_busy_clear", {31'h0, b_busy}, (m < 6) ? 1 : 0);
            if (m <= 5) drive((m == 2), 1, 1, 16'hFFFF, 2'b11, 1, 3'(m), 0, 0, 0);
            @(posedge clk);
            #1 idle_in();
        end
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 16'h0000);

        // Reset while A still holds a read in its output stage.
        wr(3, 16'h3333, 2'b11);
        rd(3, 16'h3333, 16'h3333);
        @(negedge clk);
        #2 rst_n = 1'b0;
        qa.delete();
        #1 check_reset_outputs();
        release_check();

        // Reset in the middle of a clear (counter at 4).
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        release_check();
        rd(3, 16'h0000, 16'h0000);
        rd(0, 16'h0000, 16'h0000);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
